frac_logic_param: RTL and testbench

FRAC_LOGIC_PARAM -- requirements
Module: frac_logic_param

---
 rtl/frac_logic_pkg.sv | 38 +++
 rtl/frac_logic_param_lut.sv | 30 +++
 rtl/frac_logic_param.sv | 98 +++++++++
 tb/tb_frac_logic_param.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/frac_logic_pkg.sv
// Shared constants and helpers for the fractured logic block: chain geometry,
// 2-bit routing-mux encodings and the mux evaluation itself.
package frac_logic_pkg;

  localparam logic [1:0] MUX_OFF_LO = 2'b00;
  localparam logic [1:0] MUX_SEL_A  = 2'b01;
  localparam logic [1:0] MUX_SEL_B  = 2'b10;
  localparam logic [1:0] MUX_OFF_HI = 2'b11;

  // Chain = LUT mask, then out-mux sram (S0), then in-mux sram (S1).
  function automatic int cfg_len(input int k);
    return (1 << k) + 4;
  endfunction

  function automatic int mask_lsb(input int k);
    return (k < 0) ? 0 : 0;
  endfunction

  function automatic int s0_lsb(input int k);
    return (1 << k);
  endfunction

  function automatic int s1_lsb(input int k);
    return (1 << k) + 2;
  endfunction

  // Both one-hot-invalid codes park the mux at 0.
  function automatic logic mux2(input logic [1:0] sram, input logic in_a, input logic in_b);
    logic y;
    case (sram)
      MUX_SEL_A: y = in_a;
      MUX_SEL_B: y = in_b;
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/frac_logic_param_lut.sv
// Combinational fractured K-input LUT: one K-LUT, two (K-1)-LUTs and two
// (K-2)-LUTs all read from the same mask.
module frac_lut_k #(
  parameter int K = 4
) (
  input  logic [(1<<K)-1:0] mask,
  input  logic [K-1:0]      lut_in,
  output logic              lut_k,
  output logic [1:0]        lut_k1,
  output logic [1:0]        lut_k2
);

  localparam int HALF  = 1 << (K - 1);
  localparam int QUART = 1 << (K - 2);

  logic [HALF-1:0]  half_lo;
  logic [HALF-1:0]  half_hi;
  logic [QUART-1:0] quart_lo;
  logic [QUART-1:0] quart_hi;

  assign half_lo  = mask[HALF-1:0];
  assign half_hi  = mask[2*HALF-1:HALF];
  assign quart_lo = mask[QUART-1:0];
  assign quart_hi = mask[HALF-1:QUART];

  assign lut_k  = mask[lut_in];
  assign lut_k1 = {half_hi[lut_in[K-2:0]], half_lo[lut_in[K-2:0]]};
  assign lut_k2 = {quart_hi[lut_in[K-3:0]], quart_lo[lut_in[K-3:0]]};

endmodule

// File: rtl/frac_logic_param.sv
// Fractured logic element with serial configuration chain, load counter and
// output gating. FRAC_LOGIC_CFG_PARITY_EN appends an odd-parity bit at the tail.
module frac_logic_param
  import frac_logic_pkg::*;
#(
  parameter int K = 4
) (
  input  logic         prog_clk,
  input  logic         pReset,
  input  logic [K-1:0] frac_logic_in,
  input  logic         frac_logic_cin,
  input  logic         ccff_en,
  input  logic         ccff_head,
  output logic [1:0]   frac_logic_out,
  output logic         frac_logic_cout,
  output logic         ccff_tail,
  output logic         cfg_done,
  output logic         cfg_err
);

  localparam int CFG_LEN = cfg_len(K);
`ifdef FRAC_LOGIC_CFG_PARITY_EN
  localparam int CHAIN_LEN = CFG_LEN + 1;
`else
  localparam int CHAIN_LEN = CFG_LEN;
`endif
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int M_LSB  = mask_lsb(K);
  localparam int S0_LSB = s0_lsb(K);
  localparam int S1_LSB = s1_lsb(K);

  logic [CHAIN_LEN-1:0] chain, chain_nxt;
  logic [CW-1:0]        count, count_nxt;
  logic                 done_nxt;

  always_comb begin
    chain_nxt = chain;
    count_nxt = count;
    if (ccff_en) begin
      chain_nxt = {chain[CHAIN_LEN-2:0], ccff_head};
      if (count != CW'(CHAIN_LEN)) count_nxt = count + 1'b1;
    end
  end

  assign done_nxt = (count_nxt == CW'(CHAIN_LEN));

  // Status flags are computed from next-state so done and err move together.
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      chain    <= '0;
      count    <= '0;
      cfg_done <= 1'b0;
    end else begin
      chain    <= chain_nxt;
      count    <= count_nxt;
      cfg_done <= done_nxt;
    end
  end

`ifdef FRAC_LOGIC_CFG_PARITY_EN
  always_ff @(posedge prog_clk) begin
    if (!pReset) cfg_err <= 1'b0;
    else         cfg_err <= done_nxt & ~(^chain_nxt);
  end
`else
  assign cfg_err = 1'b0;
`endif

  logic [(1<<K)-1:0] mask;
  logic [1:0]        s0, s1;
  logic [K-1:0]      lut_in;
  logic              lut_k;
  logic [1:0]        lut_k1, lut_k2;
  logic              active;

  assign mask = chain[M_LSB +: (1<<K)];
  assign s0   = chain[S0_LSB +: 2];
  assign s1   = chain[S1_LSB +: 2];

  always_comb begin
    lut_in        = frac_logic_in;
    lut_in[K-2]   = mux2(s1, frac_logic_cin, frac_logic_in[K-2]);
  end

  frac_lut_k #(.K(K)) u_lut (
    .mask   (mask),
    .lut_in (lut_in),
    .lut_k  (lut_k),
    .lut_k1 (lut_k1),
    .lut_k2 (lut_k2)
  );

  assign active          = cfg_done & ~cfg_err;
  assign frac_logic_out  = active ? {lut_k1[1], mux2(s0, lut_k, lut_k1[0])} : 2'b00;
  assign frac_logic_cout = active & (lut_k2[0] ? frac_logic_cin : lut_k2[1]);
  assign ccff_tail       = chain[CHAIN_LEN-1];

endmodule

// File: tb/tb_frac_logic_param.sv
// Directed bench for frac_logic_param (K=4 and K=6 instances sharing one clock).
module tb_frac_logic_param;

`ifdef FRAC_LOGIC_CFG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L4 = 20 + PAR;
  localparam int L6 = 68 + PAR;

  logic       prog_clk = 1'b0;
  logic       pReset   = 1'b0;
  logic [3:0] in4      = '0;
  logic       cin4     = 1'b0;
  logic       en4      = 1'b0;
  logic       head4    = 1'b0;
  logic [1:0] out4;
  logic       cout4, tail4, done4, err4;
  logic [5:0] in6      = '0;
  logic       en6      = 1'b0;
  logic       head6    = 1'b0;
  logic [1:0] out6;
  logic       cout6, tail6, done6, err6;

  int n_vec  = 0;
  int n_miss = 0;
  logic exp_q[$];

  always #5 prog_clk = ~prog_clk;

  frac_logic_param #(.K(4)) u_dut (
    .prog_clk(prog_clk), .pReset(pReset), .frac_logic_in(in4), .frac_logic_cin(cin4),
    .ccff_en(en4), .ccff_head(head4), .frac_logic_out(out4), .frac_logic_cout(cout4),
    .ccff_tail(tail4), .cfg_done(done4), .cfg_err(err4)
  );

  frac_logic_param #(.K(6)) u_dut6 (
    .prog_clk(prog_clk), .pReset(pReset), .frac_logic_in(in6), .frac_logic_cin(1'b0),
    .ccff_en(en6), .ccff_head(head6), .frac_logic_out(out6), .frac_logic_cout(cout6),
    .ccff_tail(tail6), .cfg_done(done6), .cfg_err(err6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge prog_clk);
    pReset = 1'b0; en4 = 1'b0; en6 = 1'b0;
    @(posedge prog_clk); #1;
    @(negedge prog_clk);
    pReset = 1'b1;
  endtask

  task automatic shift4(input logic b);
    @(negedge prog_clk);
    head4 = b; en4 = 1'b1;
    @(posedge prog_clk); #1;
  endtask

  task automatic shift6(input logic b);
    @(negedge prog_clk);
    head6 = b; en6 = 1'b1;
    @(posedge prog_clk); #1;
  endtask

  task automatic idle();
    @(negedge prog_clk);
    en4 = 1'b0; en6 = 1'b0;
  endtask

  // Shifts the raw chain image MSB first so it lands with v[0] at chain bit 0.
  task automatic shift_vec4(input logic [L4-1:0] v, input logic chk_done);
    for (int i = L4 - 1; i >= 0; i--) begin
      shift4(v[i]);
      if (chk_done && i == 1) check("done_before_last", done4, 0);
      if (chk_done && i == 0) check("done_on_last", done4, 1);
    end
    idle();
  endtask

  function automatic logic [L4-1:0] image4(input logic [19:0] cfg);
    logic [L4-1:0] v;
    v = L4'(cfg);
    if (PAR == 1) v[L4-1] = ~^cfg;
    return v;
  endfunction

  task automatic apply4(input logic [3:0] a, input logic c);
    in4 = a; cin4 = c; #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [L4-1:0] v;
    logic [L4-1:0] rb;
    logic          b;

    // Reset state
    repeat (2) @(posedge prog_clk);
    #1;
    check("rst_done", done4, 0);
    check("rst_err", err4, 0);
    check("rst_tail", tail4, 0);
    apply4(4'hF, 1'b1);
    check("rst_out", out4, 0);
    check("rst_cout", cout4, 0);
    @(negedge prog_clk); pReset = 1'b1;

    // M=8000, S0=01, S1=10
    v = image4({2'b10, 2'b01, 16'h8000});
    shift_vec4(v, 1'b1);
    apply4(4'hF, 1'b0); check("m8000_inF_out", out4, 2'b11); check("m8000_inF_cout", cout4, 0);
    apply4(4'hE, 1'b0); check("m8000_inE_out", out4, 2'b00);
    apply4(4'h7, 1'b0); check("m8000_in7_out", out4, 2'b10);
    check("m8000_err", err4, 0);

    // Carry: M[3:0]=0110 propagate, M[7:4]=0 generate
    do_reset();
    shift_vec4(image4({2'b10, 2'b01, 16'h0006}), 1'b0);
    apply4(4'h1, 1'b1); check("p1_cin1_cout", cout4, 1); check("p1_out", out4, 2'b01);
    apply4(4'h1, 1'b0); check("p1_cin0_cout", cout4, 0);
    apply4(4'h0, 1'b1); check("p0_cout", cout4, 0);
    apply4(4'h2, 1'b1); check("p2_cout", cout4, 1);

    // S1=01 routes cin into LUT input bit 2; generate mask = 1
    do_reset();
    shift_vec4(image4({2'b01, 2'b01, 16'h00F0}), 1'b0);
    apply4(4'h0, 1'b1); check("s1a_cin1_out", out4, 2'b01); check("s1a_cout", cout4, 1);
    apply4(4'h0, 1'b0); check("s1a_cin0_out", out4, 2'b00); check("g_cout", cout4, 1);
    apply4(4'h4, 1'b0); check("s1a_in4_out", out4, 2'b00);

    // S0=10 selects the lower (K-1)-LUT
    do_reset();
    shift_vec4(image4({2'b10, 2'b10, 16'h00F0}), 1'b0);
    apply4(4'hC, 1'b0); check("s0b_inC_out", out4, 2'b01); check("s0b_inC_cout", cout4, 1);
    apply4(4'h3, 1'b0); check("s0b_in3_out", out4, 2'b00);

    // Reset mid-load with ccff_en held high, then full reload
    do_reset();
    v = image4({2'b10, 2'b01, 16'h8000});
    for (int i = L4 - 1; i >= L4 - 10; i--) shift4(v[i]);
    check("partial_done", done4, 0);
    @(negedge prog_clk);
    pReset = 1'b0; head4 = 1'b1; en4 = 1'b1;
    @(posedge prog_clk); #1;
    check("midrst_done", done4, 0);
    check("midrst_tail", tail4, 0);
    apply4(4'hF, 1'b1);
    check("midrst_out", out4, 0);
    check("midrst_cout", cout4, 0);
    @(negedge prog_clk); pReset = 1'b1; en4 = 1'b0;
    shift_vec4(v, 1'b1);
    apply4(4'hF, 1'b0); check("reload_out", out4, 2'b11);

    // Illegal S0=11 parks out[0]; then hold chain for 50 cycles and read it back
    do_reset();
    v = image4({2'b10, 2'b11, 16'hFFFF});
    shift_vec4(v, 1'b0);
    for (int a = 0; a < 16; a++) begin
      apply4(4'(a), a[0]);
      check($sformatf("s0_11_in%0d", a), out4, 2'b10);
    end
    repeat (50) @(posedge prog_clk);
    #1;
    check("hold_tail", tail4, v[L4-1]);
    check("hold_out", out4, 2'b10);
    for (int i = L4 - 1; i >= 0; i--) begin
      rb[i] = tail4;
      shift4(1'b0);
    end
    idle();
    check("hold_readback", rb, v);
    check("done_after_extra", done4, 1);

`ifdef FRAC_LOGIC_CFG_PARITY_EN
    // Even total parity flags an error and gates outputs; one shift fixes it
    do_reset();
    v = image4({2'b10, 2'b01, 16'h8000});
    v[L4-1] = ~v[L4-1];
    shift_vec4(v, 1'b1);
    check("par_err", err4, 1);
    apply4(4'hF, 1'b1);
    check("par_out", out4, 0);
    check("par_cout", cout4, 0);
    shift4(~v[L4-1]);
    idle();
    check("par_fix_err", err4, 0);
    check("par_fix_done", done4, 1);
`endif

    // K=6: load length and tail delay
    do_reset();
    for (int i = 0; i < L6; i++) begin
      b = 1'($urandom_range(0, 1));
      exp_q.push_back(b);
      shift6(b);
      if (i == L6 - 2) check("k6_done_early", done6, 0);
    end
    check("k6_done", done6, 1);
    for (int i = 0; i < 30; i++) begin
      check($sformatf("k6_tail%0d", i), tail6, exp_q.pop_front());
      b = 1'($urandom_range(0, 1));
      exp_q.push_back(b);
      shift6(b);
    end
    idle();
    check("k6_tail_end", tail6, exp_q.pop_front());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
